// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: ROB sizing, opcode and entry-type
// constants, and the ROB entry payload.
package tomasulo_pkg;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned TAG_W  = 3;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned CNT_W  = TAG_W + 1;

    // Issue-stage opcodes
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_MUL   = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_LOAD  = 4'b0100;
    localparam logic [3:0] OP_STORE = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_BNEQ  = 4'b0111;

    // ROB entry kinds
    typedef enum logic [1:0] {
        T_REG    = 2'd0,
        T_STORE  = 2'd1,
        T_BRANCH = 2'd2
    } rob_type_e;

    typedef struct packed {
        logic              busy;
        logic              ready;
        rob_type_e         typ;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] value;
        logic              mispredict;
    } rob_entry_t;

endpackage

// File: rtl/rob_operand_read.sv
// Combinational operand lookup into the ROB with same-cycle CDB forwarding.
// Ports:
//   i_tag                         - tag being looked up
//   i_busy / i_ready / i_value    - per-entry ROB state
//   i_cdb_valid/_tag/_value       - current CDB broadcast
//   o_ready_c / o_value_c         - value available and its contents
module rob_operand_read
    import tomasulo_pkg::*;
(
    input  logic [TAG_W-1:0]             i_tag,
    input  logic [DEPTH-1:0]             i_busy,
    input  logic [DEPTH-1:0]             i_ready,
    input  logic [DEPTH-1:0][DATA_W-1:0] i_value,
    input  logic                         i_cdb_valid,
    input  logic [TAG_W-1:0]             i_cdb_tag,
    input  logic [DATA_W-1:0]            i_cdb_value,
    output logic                         o_ready_c,
    output logic [DATA_W-1:0]            o_value_c
);

    // Only busy entries answer; a live CDB hit wins over the stored value.
    always_comb begin
        o_ready_c = 1'b0;
        o_value_c = '0;
        if (i_busy[i_tag]) begin
            if (i_cdb_valid && (i_cdb_tag == i_tag)) begin
                o_ready_c = 1'b1;
                o_value_c = i_cdb_value;
            end else if (i_ready[i_tag]) begin
                o_ready_c = 1'b1;
                o_value_c = i_value[i_tag];
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Eight-entry in-order reorder buffer: allocates tags at issue, captures CDB
// results, retires one entry per cycle in program order and flushes all
// speculative state when a mispredicted branch retires.
// Ports:
//   clk1, rst                       - clock, synchronous active-high reset
//   alloc_valid/_type/_dest         - issue request; alloc_ready/alloc_tag grant
//   cdb_valid/_tag/_value/_mispredict - result broadcast
//   src1/2_tag -> src1/2_ready/_value - combinational operand lookup
//   commit_*                        - registered retire pulse and contents
//   flush                           - registered pulse with a mispredict retire
//   count                           - occupied entries
module reorder_buffer
    import tomasulo_pkg::*;
(
    input  logic              clk1,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic [1:0]        alloc_type,
    input  logic [REG_W-1:0]  alloc_dest,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    input  logic              cdb_mispredict,
    input  logic [TAG_W-1:0]  src1_tag,
    input  logic [TAG_W-1:0]  src2_tag,
    output logic              src1_ready,
    output logic              src2_ready,
    output logic [DATA_W-1:0] src1_value,
    output logic [DATA_W-1:0] src2_value,
    output logic              commit_valid,
    output logic [1:0]        commit_type,
    output logic [REG_W-1:0]  commit_dest,
    output logic [DATA_W-1:0] commit_value,
    output logic [TAG_W-1:0]  commit_tag,
    output logic              flush,
    output logic [CNT_W-1:0]  count
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    rob_entry_t        r_rob [DEPTH];
    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_commit_valid;
    logic [1:0]        r_commit_type;
    logic [REG_W-1:0]  r_commit_dest;
    logic [DATA_W-1:0] r_commit_value;
    logic [TAG_W-1:0]  r_commit_tag;
    logic              r_flush;

    rob_entry_t                 w_head;
    logic                       w_commit;
    logic                       w_flush;
    logic                       w_alloc_ready;
    logic                       w_alloc;
    logic [DEPTH-1:0]           w_busy;
    logic [DEPTH-1:0]           w_ready;
    logic [DEPTH-1:0][DATA_W-1:0] w_value;

    // Retire / flush decision on the head entry; a pending flush blocks alloc.
    always_comb begin
        w_head        = r_rob[r_head];
        w_commit      = w_head.busy && w_head.ready;
        w_flush       = w_commit && (w_head.typ == T_BRANCH) && w_head.mispredict;
        w_alloc_ready = (r_count != FULL_CNT) && !w_flush;
        w_alloc       = alloc_valid && w_alloc_ready;
    end

    // Flatten entry state for the lookup ports.
    always_comb begin
        w_busy  = '0;
        w_ready = '0;
        w_value = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_busy[i]  = r_rob[i].busy;
            w_ready[i] = r_rob[i].ready;
            w_value[i] = r_rob[i].value;
        end
    end

    // Entry, pointer, occupancy and retire-port state.
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= 1'b0;
            r_commit_type  <= '0;
            r_commit_dest  <= '0;
            r_commit_value <= '0;
            r_commit_tag   <= '0;
            r_flush        <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_rob[i] <= '0;
            end
        end else begin
            r_commit_valid <= w_commit;
            r_flush        <= w_flush;
            if (w_commit) begin
                r_commit_type  <= w_head.typ;
                r_commit_dest  <= w_head.dest;
                r_commit_value <= w_head.value;
                r_commit_tag   <= r_head;
            end

            if (w_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    r_rob[i] <= '0;
                end
            end else begin
                // Results for entries not in flight are dropped.
                if (cdb_valid && r_rob[cdb_tag].busy) begin
                    r_rob[cdb_tag].ready      <= 1'b1;
                    r_rob[cdb_tag].value      <= cdb_value;
                    r_rob[cdb_tag].mispredict <= cdb_mispredict;
                end
                if (w_commit) begin
                    r_rob[r_head].busy  <= 1'b0;
                    r_rob[r_head].ready <= 1'b0;
                    r_head              <= r_head + TAG_W'(1);
                end
                // Tail slot is never the committing head: that needs empty or full.
                if (w_alloc) begin
                    r_rob[r_tail] <= '{busy:       1'b1,
                                       ready:      1'b0,
                                       typ:        rob_type_e'(alloc_type),
                                       dest:       alloc_dest,
                                       value:      '0,
                                       mispredict: 1'b0};
                    r_tail        <= r_tail + TAG_W'(1);
                end
                r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_commit);
            end
        end
    end

    rob_operand_read u_src1_read (
        .i_tag       (src1_tag),
        .i_busy      (w_busy),
        .i_ready     (w_ready),
        .i_value     (w_value),
        .i_cdb_valid (cdb_valid),
        .i_cdb_tag   (cdb_tag),
        .i_cdb_value (cdb_value),
        .o_ready_c   (src1_ready),
        .o_value_c   (src1_value)
    );

    rob_operand_read u_src2_read (
        .i_tag       (src2_tag),
        .i_busy      (w_busy),
        .i_ready     (w_ready),
        .i_value     (w_value),
        .i_cdb_valid (cdb_valid),
        .i_cdb_tag   (cdb_tag),
        .i_cdb_value (cdb_value),
        .o_ready_c   (src2_ready),
        .o_value_c   (src2_value)
    );

    assign alloc_ready  = w_alloc_ready;
    assign alloc_tag    = r_tail;
    assign count        = r_count;
    assign commit_valid = r_commit_valid;
    assign commit_type  = r_commit_type;
    assign commit_dest  = r_commit_dest;
    assign commit_value = r_commit_value;
    assign commit_tag   = r_commit_tag;
    assign flush        = r_flush;

endmodule
